// File: rtl/wb_i2c_arbiter.sv
// Round-robin lock arbiter sharing one I2C-core wishbone slave among N_REQ masters.
// A grant is held for a whole multi-byte transaction; a watchdog aborts a silent owner.
module wb_i2c_arbiter #(
   parameter int unsigned N_REQ       = 3,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [N_REQ-1:0]   i_req,
   output logic [N_REQ-1:0]   o_gnt,
   input  logic [3*N_REQ-1:0] i_m_adr,
   input  logic [8*N_REQ-1:0] i_m_dat,
   input  logic [N_REQ-1:0]   i_m_we,
   input  logic [N_REQ-1:0]   i_m_stb,
   input  logic [N_REQ-1:0]   i_m_cyc,
   output logic [7:0]         o_m_dat,
   output logic [N_REQ-1:0]   o_m_ack,
   output logic [N_REQ-1:0]   o_m_err,
   output logic [2:0]         o_wbs_adr,
   output logic [7:0]         o_wbs_dat,
   output logic               o_wbs_we,
   output logic               o_wbs_stb,
   output logic               o_wbs_cyc,
   input  logic [7:0]         i_wbs_dat,
   input  logic               i_wbs_ack,
   output logic               o_busy,
   output logic [1:0]         o_owner
);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease, StAbort} state_e;

   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYC);
   localparam logic [1:0]  LastIdx    = 2'(N_REQ - 1);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] block_q, block_d;
   logic [N_REQ-1:0] err_q, err_d;
   logic [1:0]       owner_q, owner_d;
   logic [15:0]      wdog_q, wdog_d;

   logic [N_REQ-1:0] elig;
   logic [1:0]       pick_idx;
   logic [1:0]       cand;
   logic             pick_found;
   logic             own_req, own_cyc, own_stb, own_we;
   logic [2:0]       own_adr;
   logic [7:0]       own_dat;
   logic             fwd;

   // Owner slice, selected by the one-hot grant so non-owners contribute nothing.
   always_comb begin
      own_adr = '0;
      own_dat = '0;
      own_we  = 1'b0;
      own_stb = 1'b0;
      own_cyc = 1'b0;
      own_req = 1'b0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         if (gnt_q[k]) begin
            own_adr = i_m_adr[3*k +: 3];
            own_dat = i_m_dat[8*k +: 8];
            own_we  = i_m_we[k];
            own_stb = i_m_stb[k];
            own_cyc = i_m_cyc[k];
            own_req = i_req[k];
         end
      end
   end

   // Round-robin search starting just after the last owner.
   always_comb begin
      elig       = i_req & ~block_q;
      pick_idx   = owner_q;
      pick_found = 1'b0;
      cand       = '0;
      for (int i = 1; i <= int'(N_REQ); i++) begin
         cand = 2'((int'(owner_q) + i) % int'(N_REQ));
         if (!pick_found && elig[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      o_wbs_adr = '0;
      o_wbs_dat = '0;
      o_wbs_we  = 1'b0;
      o_wbs_stb = 1'b0;
      o_wbs_cyc = 1'b0;
      unique case (state_q)
         StGrant: fwd = 1'b1;
         // An aborting owner may only finish the strobe already on the bus.
         StAbort: fwd = own_stb;
         default: fwd = 1'b0;
      endcase
      if (fwd) begin
         o_wbs_adr = own_adr;
         o_wbs_dat = own_dat;
         o_wbs_we  = own_we;
         o_wbs_stb = own_stb;
         o_wbs_cyc = own_cyc;
      end
      o_m_ack = (fwd && i_wbs_ack) ? gnt_q : '0;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      wdog_d  = wdog_q;
      err_d   = '0;
      block_d = block_q & i_req;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               owner_d         = pick_idx;
               wdog_d          = '0;
               state_d         = StGrant;
            end
         end
         StGrant: begin
            if (!own_req && !own_cyc) begin
               gnt_d   = '0;
               state_d = StRelease;
            end else if (wdog_q == TimeoutVal) begin
               state_d = StAbort;
            end else if (i_wbs_ack) begin
               wdog_d = '0;
            end else if (wdog_q != 16'hFFFF) begin
               wdog_d = wdog_q + 16'd1;
            end
         end
         StRelease: state_d = StIdle;
         StAbort: begin
            if (!own_stb || i_wbs_ack) begin
               err_d   = gnt_q;
               block_d = block_d | gnt_q;
               gnt_d   = '0;
               state_d = StRelease;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         block_q <= '0;
         err_q   <= '0;
         owner_q <= LastIdx;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         block_q <= block_d;
         err_q   <= err_d;
         owner_q <= owner_d;
         wdog_q  <= wdog_d;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_m_err = err_q;
   assign o_owner = owner_q;
   assign o_m_dat = i_wbs_dat;
   assign o_busy  = (state_q == StGrant) || (state_q == StAbort);

endmodule

// File: tb/tb_wb_i2c_arbiter.sv
// Directed-plus-random bench for wb_i2c_arbiter; grant order comes from a round-robin model.
module tb_wb_i2c_arbiter;

   localparam int N  = 3;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   o_gnt;
   logic [3*N-1:0] m_adr;
   logic [8*N-1:0] m_dat;
   logic [N-1:0]   m_we, m_stb, m_cyc;
   logic [7:0]     o_m_dat;
   logic [N-1:0]   o_m_ack, o_m_err;
   logic [2:0]     o_wbs_adr;
   logic [7:0]     o_wbs_dat;
   logic           o_wbs_we, o_wbs_stb, o_wbs_cyc;
   logic [7:0]     wbs_dat;
   logic           wbs_ack;
   logic           o_busy;
   logic [1:0]     o_owner;

   int n_cmp = 0;
   int n_bad = 0;
   int last_owner;
   int cur;
   logic [N-1:0] blocked;
   int order[4] = '{1, 2, 0, 1};

   always #5 clk = ~clk;

   wb_i2c_arbiter #(
      .N_REQ       (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_req     (req),
      .o_gnt     (o_gnt),
      .i_m_adr   (m_adr),
      .i_m_dat   (m_dat),
      .i_m_we    (m_we),
      .i_m_stb   (m_stb),
      .i_m_cyc   (m_cyc),
      .o_m_dat   (o_m_dat),
      .o_m_ack   (o_m_ack),
      .o_m_err   (o_m_err),
      .o_wbs_adr (o_wbs_adr),
      .o_wbs_dat (o_wbs_dat),
      .o_wbs_we  (o_wbs_we),
      .o_wbs_stb (o_wbs_stb),
      .o_wbs_cyc (o_wbs_cyc),
      .i_wbs_dat (wbs_dat),
      .i_wbs_ack (wbs_ack),
      .o_busy    (o_busy),
      .o_owner   (o_owner)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int k);
      return (k < 0) ? 32'd0 : (32'd1 << k);
   endfunction

   // Reference arbitration rule: first eligible index after the last owner, wrapping.
   function automatic int rr(input int last, input logic [N-1:0] mask);
      int c;
      for (int i = 1; i <= N; i++) begin
         c = (last + i) % N;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_m(input int k, input logic [2:0] a, input logic [7:0] d, input logic w,
                        input logic s, input logic c);
      m_adr[3*k +: 3] = a;
      m_dat[8*k +: 8] = d;
      m_we[k]         = w;
      m_stb[k]        = s;
      m_cyc[k]        = c;
   endtask

   task automatic expect_grant(input string tag, input logic [N-1:0] mask);
      int e;
      e = rr(last_owner, mask & ~blocked);
      tick();
      chk({tag, "_gnt"}, 32'(o_gnt), oh(e));
      chk({tag, "_owner"}, 32'(o_owner), 32'(e));
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      last_owner = e;
      cur        = e;
   endtask

   // One owner access while another requester strobes a different address.
   task automatic txn(input int k);
      logic [2:0] a;
      logic [7:0] d, rd;
      logic       w;
      int         dly, j;
      a   = 3'($urandom);
      d   = 8'($urandom);
      rd  = 8'($urandom);
      w   = 1'($urandom);
      dly = $urandom_range(3, 0);
      j   = (k + 1 + $urandom_range(1, 0)) % N;
      set_m(k, a, d, w, 1'b1, 1'b1);
      set_m(j, ~a, 8'($urandom), 1'b1, 1'b1, 1'b1);
      repeat (dly) begin
         #1;
         chk("txn_adr_wait", 32'(o_wbs_adr), 32'(a));
         chk("txn_stb_wait", 32'(o_wbs_stb), 32'd1);
         chk("txn_noack", 32'(o_m_ack), 32'd0);
         tick();
      end
      wbs_ack = 1'b1;
      wbs_dat = rd;
      #1;
      chk("txn_ack", 32'(o_m_ack), oh(k));
      chk("txn_rdat", 32'(o_m_dat), 32'(rd));
      chk("txn_adr", 32'(o_wbs_adr), 32'(a));
      chk("txn_wdat", 32'(o_wbs_dat), 32'(d));
      chk("txn_we", 32'(o_wbs_we), 32'(w));
      tick();
      wbs_ack = 1'b0;
      set_m(k, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      set_m(j, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Owner gives up the lock (optionally with cyc still high); next_mask arrives during release.
   task automatic release_owner(input bit late, input logic [N-1:0] next_mask);
      int n;
      req[cur] = 1'b0;
      if (late) begin
         m_cyc[cur] = 1'b1;
         n = $urandom_range(4, 1);
         repeat (n) begin
            tick();
            chk("late_hold_gnt", 32'(o_gnt), oh(cur));
            chk("late_hold_cyc", 32'(o_wbs_cyc), 32'd1);
         end
         m_cyc[cur] = 1'b0;
      end
      tick();
      chk("rel_gnt", 32'(o_gnt), 32'd0);
      chk("rel_busy", 32'(o_busy), 32'd0);
      chk("rel_wbs_cyc", 32'(o_wbs_cyc), 32'd0);
      req = next_mask;
      tick();
      chk("idle_gnt", 32'(o_gnt), 32'd0);
   endtask

   initial begin
      int k;
      logic [N-1:0] mask;
      rst_n      = 1'b0;
      req        = '0;
      m_adr      = '0;
      m_dat      = '0;
      m_we       = '0;
      m_stb      = '0;
      m_cyc      = '0;
      wbs_ack    = 1'b0;
      wbs_dat    = '0;
      last_owner = N - 1;
      cur        = 0;
      blocked    = '0;

      tick();
      #1;
      chk("rst_gnt", 32'(o_gnt), 32'd0);
      chk("rst_owner", 32'(o_owner), 32'(N - 1));
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_wbs_cyc", 32'(o_wbs_cyc), 32'd0);
      chk("rst_err", 32'(o_m_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Simultaneous first request.
      req = '1;
      expect_grant("first", '1);
      chk("first_is_req0", 32'(o_gnt), 32'd1);

      // Rotation with all requests held.
      for (int r = 0; r < 4; r++) begin
         txn(cur);
         release_owner(1'b0, '1);
         expect_grant("rot", '1);
         chk("rot_order", 32'(o_owner), 32'(order[r]));
      end

      // Owner 1 writes CR while requester 2 strobes.
      set_m(1, 3'b100, 8'h90, 1'b1, 1'b1, 1'b1);
      set_m(2, 3'b011, 8'h55, 1'b0, 1'b1, 1'b1);
      #1;
      chk("iso_adr", 32'(o_wbs_adr), 32'd4);
      chk("iso_dat", 32'(o_wbs_dat), 32'h90);
      chk("iso_we", 32'(o_wbs_we), 32'd1);
      tick();
      wbs_ack = 1'b1;
      #1;
      chk("iso_ack", 32'(o_m_ack), 32'b010);
      chk("iso_adr_ack", 32'(o_wbs_adr), 32'd4);
      tick();
      wbs_ack = 1'b0;
      set_m(1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("iso_stall_stb", 32'(o_wbs_stb), 32'd0);
      chk("iso_stall_adr", 32'(o_wbs_adr), 32'd0);
      tick();
      set_m(2, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Late release: req drops while cyc stays high.
      release_owner(1'b1, '1);
      expect_grant("after_late", '1);

      for (int r = 0; r < 12; r++) begin
         int ntx;
         ntx = $urandom_range(2, 0);
         for (int t = 0; t < ntx; t++) txn(cur);
         mask = N'($urandom_range(7, 0));
         release_owner(1'($urandom_range(1, 0)), mask);
         if (mask == '0) begin
            tick();
            chk("noreq_gnt", 32'(o_gnt), 32'd0);
            mask = N'($urandom_range(7, 1));
            req  = mask;
         end
         expect_grant("rand", mask);
      end

      // Watchdog: owner holds the lock with no access, so no ack ever comes.
      release_owner(1'b0, '1);
      expect_grant("pre_to", '1);
      k = cur;
      for (int j = 1; j <= TO + 1; j++) begin
         tick();
         chk("to_hold_gnt", 32'(o_gnt), oh(k));
         chk("to_no_err", 32'(o_m_err), 32'd0);
      end
      tick();
      chk("to_err", 32'(o_m_err), oh(k));
      chk("to_gnt_drop", 32'(o_gnt), 32'd0);
      blocked[k] = 1'b1;
      tick();
      chk("to_err_pulse", 32'(o_m_err), 32'd0);
      expect_grant("to_next", '1);
      release_owner(1'b0, N'(oh(k)));
      repeat (3) begin
         tick();
         chk("blocked_ignored", 32'(o_gnt), 32'd0);
      end
      req[k] = 1'b0;
      tick();
      blocked[k] = 1'b0;
      req[k]     = 1'b1;
      expect_grant("unblocked", N'(oh(k)));

      // Asynchronous reset in the middle of a transfer.
      set_m(cur, 3'b010, 8'hA5, 1'b1, 1'b1, 1'b1);
      #1;
      chk("pre_rst_cyc", 32'(o_wbs_cyc), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_cyc", 32'(o_wbs_cyc), 32'd0);
      chk("arst_stb", 32'(o_wbs_stb), 32'd0);
      chk("arst_gnt", 32'(o_gnt), 32'd0);
      chk("arst_owner", 32'(o_owner), 32'(N - 1));
      set_m(cur, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      req = '1;
      tick();
      rst_n      = 1'b1;
      last_owner = N - 1;
      blocked    = '0;
      expect_grant("post_rst", '1);
      chk("post_rst_owner0", 32'(o_owner), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
